// File: rtl/redirect_sequencer.sv
// PC-redirect and flush controller: arbitrates branch, exception and ERET events for the pipeline.
// Define REDIRECT_EXL_EN to add the EXL flag (exl output) that masks exceptions until ERET.
module redirect_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_8000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  input  logic [3:0]   exc_req,
  input  logic [19:0]  exc_code,
  input  logic [127:0] exc_pc,
  input  logic         eret,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc,
  output logic [3:0]   flush,
  output logic         stall_front,
  output logic [31:0]  epc_out,
  output logic [4:0]   cause_out,
`ifdef REDIRECT_EXL_EN
  output logic         exl,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, DRAIN, VECTOR} state_e;

  state_e      state_q, state_d;
  logic [3:0]  drainCnt_q, drainCnt_d;
  logic        rv_q, rv_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  flush_q, flush_d;
  logic        stall_q, stall_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic        busy_q, busy_d;
`ifdef REDIRECT_EXL_EN
  logic        exl_q, exl_d;
`endif

  logic [3:0]  excEff;
  logic        excTake;
  logic [1:0]  win;
  logic [3:0]  winMask;
  logic [31:0] winPc;
  logic [4:0]  winCode;

  // Oldest instruction (highest stage) wins; a lone IF fault yields to a taken branch.
  always_comb begin
`ifdef REDIRECT_EXL_EN
    excEff = exl_q ? 4'b0000 : exc_req;
`else
    excEff = exc_req;
`endif
    win = 2'd0;
    if (excEff[1]) win = 2'd1;
    if (excEff[2]) win = 2'd2;
    if (excEff[3]) win = 2'd3;
    case (win)
      2'd0:    begin winMask = 4'b0001; winPc = exc_pc[31:0];   winCode = exc_code[4:0];   end
      2'd1:    begin winMask = 4'b0011; winPc = exc_pc[63:32];  winCode = exc_code[9:5];   end
      2'd2:    begin winMask = 4'b0111; winPc = exc_pc[95:64];  winCode = exc_code[14:10]; end
      default: begin winMask = 4'b1111; winPc = exc_pc[127:96]; winCode = exc_code[19:15]; end
    endcase
    excTake = (|excEff[3:1]) || (excEff[0] && !br_taken);
  end

  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    rv_d       = 1'b0;
    pc_d       = 32'h0;
    flush_d    = 4'b0000;
    stall_d    = 1'b0;
    epc_d      = epc_q;
    cause_d    = cause_q;
`ifdef REDIRECT_EXL_EN
    exl_d      = exl_q;
`endif
    case (state_q)
      IDLE: begin
        if (excTake) begin
          state_d    = DRAIN;
          drainCnt_d = 4'(FLUSH_CYCLES - 1);
          flush_d    = winMask;
          stall_d    = 1'b1;
          epc_d      = winPc;
          cause_d    = winCode;
`ifdef REDIRECT_EXL_EN
          exl_d      = 1'b1;
`endif
        end else if (br_taken) begin
          rv_d    = 1'b1;
          pc_d    = br_target;
          flush_d = 4'b0001;
        end else if (eret) begin
          rv_d    = 1'b1;
          pc_d    = epc_q;
          flush_d = 4'b0011;
`ifdef REDIRECT_EXL_EN
          exl_d   = 1'b0;
`endif
        end
      end
      DRAIN: begin
        flush_d = flush_q;
        stall_d = 1'b1;
        if (drainCnt_q == 4'd0) begin
          state_d = VECTOR;
          rv_d    = 1'b1;
          pc_d    = EXC_VECTOR;
          flush_d = 4'b0000;
          stall_d = 1'b0;
        end else begin
          drainCnt_d = drainCnt_q - 4'd1;
        end
      end
      VECTOR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      drainCnt_q <= 4'd0;
      rv_q       <= 1'b0;
      pc_q       <= 32'h0;
      flush_q    <= 4'b0000;
      stall_q    <= 1'b0;
      epc_q      <= 32'h0;
      cause_q    <= 5'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      rv_q       <= rv_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      stall_q    <= stall_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      busy_q     <= busy_d;
    end
  end

`ifdef REDIRECT_EXL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exl_q <= 1'b0;
    else     exl_q <= exl_d;
  end
  assign exl = exl_q;
`endif

  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;
  assign flush          = flush_q;
  assign stall_front    = stall_q;
  assign epc_out        = epc_q;
  assign cause_out      = cause_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_redirect_sequencer.sv
// Self-checking bench for redirect_sequencer: directed scenarios followed by random traffic
// compared against a queue-based reference model of the expected output stream.
module tb_redirect_sequencer;

  localparam logic [31:0] EXC_VECTOR   = 32'h0000_8000;
  localparam int          FLUSH_CYCLES = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         br_taken = 1'b0;
  logic [31:0]  br_target = '0;
  logic [3:0]   exc_req = '0;
  logic [19:0]  exc_code = '0;
  logic [127:0] exc_pc = '0;
  logic         eret = 1'b0;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [3:0]   flush;
  logic         stall_front;
  logic [31:0]  epc_out;
  logic [4:0]   cause_out;
  logic         busy;

  always #5 clk = ~clk;

  redirect_sequencer #(.EXC_VECTOR(EXC_VECTOR), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .eret(eret),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .stall_front(stall_front), .epc_out(epc_out), .cause_out(cause_out), .busy(busy)
  );

  typedef struct packed {
    logic        rv;
    logic [31:0] pc;
    logic [3:0]  fl;
    logic        st;
    logic        bz;
  } exp_t;

  // The model schedules whole exception sequences into a queue of expected cycles.
  exp_t        expQ[$];
  exp_t        cur;
  logic [31:0] mEpc;
  logic [4:0]  mCause;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    cur    = '0;
    mEpc   = '0;
    mCause = '0;
  endtask

  task automatic modelStep();
    int   w;
    exp_t v;
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
    end else begin
      cur = '0;
      if (exc_req > 4'd1 || (exc_req == 4'd1 && !br_taken)) begin
        w = 0;
        for (int i = 0; i < 4; i++) if (exc_req[i]) w = i;
        mEpc   = exc_pc[32*w +: 32];
        mCause = exc_code[5*w +: 5];
        cur.fl = 4'((1 << (w + 1)) - 1);
        cur.st = 1'b1;
        cur.bz = 1'b1;
        for (int k = 1; k < FLUSH_CYCLES; k++) expQ.push_back(cur);
        v = '0; v.rv = 1'b1; v.pc = EXC_VECTOR; v.bz = 1'b1;
        expQ.push_back(v);
        v = '0;
        expQ.push_back(v);
      end else if (br_taken) begin
        cur.rv = 1'b1; cur.pc = br_target; cur.fl = 4'b0001;
      end else if (eret) begin
        cur.rv = 1'b1; cur.pc = mEpc; cur.fl = 4'b0011;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".rv"},    32'(redirect_valid), 32'(cur.rv));
    chk({tag, ".pc"},    redirect_pc,         cur.pc);
    chk({tag, ".flush"}, 32'(flush),          32'(cur.fl));
    chk({tag, ".stall"}, 32'(stall_front),    32'(cur.st));
    chk({tag, ".busy"},  32'(busy),           32'(cur.bz));
    chk({tag, ".epc"},   epc_out,             mEpc);
    chk({tag, ".cause"}, 32'(cause_out),      32'(mCause));
  endtask

  task automatic applyStimulus(input string tag, input logic br, input logic [31:0] tgt,
                               input logic [3:0] exc, input logic er,
                               input logic [19:0] codes, input logic [127:0] pcs);
    @(negedge clk);
    br_taken  = br;
    br_target = tgt;
    exc_req   = exc;
    eret      = er;
    exc_code  = codes;
    exc_pc    = pcs;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 32'h0, 4'b0000, 1'b0, 20'h0, 128'h0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [19:0]  codes;
    logic [127:0] pcs;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("br", 1'b1, 32'h0000_0040, 4'b0000, 1'b0, 20'h0, 128'h0);
    chk("br.const.pc", redirect_pc, 32'h0000_0040);
    chk("br.const.flush", 32'(flush), 32'h1);
    idle("br.after");
    chk("br.after.rv", 32'(redirect_valid), 32'h0);

    codes = 20'h0; codes[14:10] = 5'd12;
    pcs = 128'h0;  pcs[95:64] = 32'h0000_0100;
    applyStimulus("exEx", 1'b0, 32'h0, 4'b0100, 1'b0, codes, pcs);
    chk("exEx.const.epc", epc_out, 32'h0000_0100);
    chk("exEx.const.cause", 32'(cause_out), 32'd12);
    chk("exEx.const.flush", 32'(flush), 32'h7);
    idle("exEx.drain2");
    chk("exEx.const.stall", 32'(stall_front), 32'h1);
    idle("exEx.vector");
    chk("exEx.const.vec", redirect_pc, 32'h0000_8000);
    idle("exEx.done");
    chk("exEx.const.busy", 32'(busy), 32'h0);

    codes = 20'h0; codes[19:15] = 5'd7; codes[9:5] = 5'd3;
    pcs = 128'h0;  pcs[127:96] = 32'h0000_0200; pcs[63:32] = 32'h0000_0300;
    applyStimulus("exMem", 1'b1, 32'h0000_0999, 4'b1010, 1'b0, codes, pcs);
    chk("exMem.const.epc", epc_out, 32'h0000_0200);
    chk("exMem.const.flush", 32'(flush), 32'hF);
    chk("exMem.const.rv", 32'(redirect_valid), 32'h0);
    idle("exMem.d2");
    idle("exMem.vec");
    idle("exMem.done");

    pcs = 128'h0; pcs[31:0] = 32'h0000_0400;
    applyStimulus("ifDrop", 1'b1, 32'h0000_0500, 4'b0001, 1'b0, 20'h1F, pcs);
    chk("ifDrop.const.epc", epc_out, 32'h0000_0200);
    chk("ifDrop.const.pc", redirect_pc, 32'h0000_0500);

    applyStimulus("eret", 1'b0, 32'h0, 4'b0000, 1'b1, 20'h0, 128'h0);
    chk("eret.const.pc", redirect_pc, 32'h0000_0200);
    chk("eret.const.flush", 32'(flush), 32'h3);
    applyStimulus("b2b", 1'b1, 32'h0000_0600, 4'b0000, 1'b0, 20'h0, 128'h0);
    idle("b2b.after");

    pcs = 128'h0; pcs[63:32] = 32'h0000_0700;
    applyStimulus("rstExc", 1'b0, 32'h0, 4'b0010, 1'b1, 20'h0, pcs);
    @(negedge clk);
    exc_req = 4'b0000;
    eret    = 1'b0;
    rst     = 1'b1;
    #1;
    modelReset();
    checkOutput("rstDrain");
    #2;
    rst = 1'b0;
    applyStimulus("postRst", 1'b1, 32'h0000_0080, 4'b0000, 1'b0, 20'h0, 128'h0);
    chk("postRst.const.pc", redirect_pc, 32'h0000_0080);

    for (int n = 0; n < 600; n++) begin
      applyStimulus("rand", ($urandom_range(0, 3) == 0), $urandom,
                    ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                    ($urandom_range(0, 5) == 0), 20'($urandom),
                    {$urandom, $urandom, $urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
